tx_scheduler: RTL and testbench
===============================

// Module: tx_scheduler
// PURPOSE
//  Owns the shared serial TX channel. Arbitrates between the prefetcher (READ_16 instruction fetches)
//  and the memory unit (loads/stores), then serialises start marker, command header and payload.
//  Records the owner of every command that expects a response, in order, so RX data reaches the right unit.
// PARAMETERS
//  IO_BITS          2  pins per cycle on tx_pins and payload buses
//  PAYLOAD_CYCLES   8  payload cycles per frame (PAYLOAD_CYCLES*IO_BITS address/data bits)
//  CMD_BITS         3  command header width; HDR_CYCLES = ceil(CMD_BITS/IO_BITS)
//  MAX_OUTSTANDING  2  owner-FIFO depth (response-expecting commands in flight)
// PORTS
//  clk            in   1                         clock
//  rst_n          in   1                         asynchronous reset, active low
//  pf_cmd_valid   in   1                         prefetcher requests a frame
//  pf_cmd         in   CMD_BITS                  prefetcher header; always expects a response
//  pf_started     out  1                         pulse: prefetcher request granted
//  pf_data        in   IO_BITS                   prefetcher payload bits (PC), sampled when pf_data_next
//  pf_data_next   out  1                         prefetcher payload cycle; advance its shift register
//  mem_cmd_valid  in   1                         memory unit requests a frame
//  mem_cmd        in   CMD_BITS                  memory-unit header
//  mem_expect_rsp in   1                         memory frame expects a response (load=1, store=0)
//  mem_started    out  1                         pulse: memory request granted
//  mem_data       in   IO_BITS                   memory payload bits, sampled when mem_data_next
//  mem_data_next  out  1                         memory payload cycle
//  tx_pins        out  IO_BITS                   serial output
//  tx_active      out  1                         frame in progress (START..PAYLOAD)
//  tx_counter     out  $clog2(PAYLOAD_CYCLES)+1  cycle index within HEADER or PAYLOAD phase
//  tx_done        out  1                         high in last payload cycle
//  rx_done        in   1                         a response has fully arrived; pop owner FIFO
//  rx_owner_valid out  1                         owner FIFO non-empty
//  rx_owner_pf    out  1                         head owner: 1=prefetcher, 0=memory unit
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, tx_pins=0, all pulses/active 0, tx_counter=0, FIFO empty,
//   rr_last=mem (so prefetcher wins first tie).
//  States: IDLE -> START (1 cyc) -> HEADER (HDR_CYCLES) -> PAYLOAD (PAYLOAD_CYCLES) -> IDLE.
//  IDLE: tx_pins=0. Eligible = valid && (no response needed || FIFO not full, counting same-cycle pop).
//   One eligible -> grant it; both -> grant the one not granted last (round robin). Grant cycle:
//   *_started=1 (combinational, one cycle), latch owner and cmd, FIFO push if response expected, go START.
//   No eligible -> stay IDLE. Requesters hold valid until started; deasserting earlier is allowed.
//  START: tx_pins={{(IO_BITS-1){1'b0}},1'b1}. HEADER: latched cmd LSB first, IO_BITS/cycle, zero-padded;
//   tx_counter 0..HDR_CYCLES-1.
//  PAYLOAD: tx_pins = granted *_data (combinational pass-through); granted *_data_next=1 every cycle;
//   tx_counter 0..PAYLOAD_CYCLES-1; tx_done=1 when tx_counter==PAYLOAD_CYCLES-1; then IDLE.
//  Minimum gap: exactly one IDLE cycle between frames; frame length 1+1+HDR_CYCLES+PAYLOAD_CYCLES incl. grant.
//  Owner FIFO: push on grant, pop on rx_done; simultaneous push+pop keeps count; pop when empty ignored
//   (RX protocol error, no state change); push never happens when full (eligibility rule).
//  tx_counter width covers both phases; resets to 0 at each phase entry. Only one *_started/_data_next high at a time.
// TESTING
//  pf only, pf_cmd=3'b011, pf_data walks 0..3 -> pf_started at t, tx_pins 01 @t+1, 11,00 header, 8 payload
//   cycles echo pf_data, tx_done @t+11; rx_owner_pf=1, rx_owner_valid=1.
//  pf and mem valid same IDLE cycle after reset -> pf granted; both held -> next grant mem, then pf (alternate).
//  MAX_OUTSTANDING=2: two pf frames without rx_done -> third pf stays ungranted; mem store (expect_rsp=0) still
//   granted; rx_done pops -> pf granted in that same IDLE cycle.
//  Responses: grant pf, mem load, pf -> rx_done x3 yields rx_owner_pf sequence 1,0,1 then rx_owner_valid=0.
//  rst_n low in PAYLOAD cycle 4 -> tx_pins=0, tx_active=0, FIFO empty immediately; resumes clean frame after release.
//  rx_done while FIFO empty -> no change; simultaneous push+pop at count=2 -> count stays 2, order kept.

Source files
------------

// File: rtl/tx_scheduler.sv
// Shared serial TX channel: round-robin grant between prefetcher and memory unit, then START/HEADER/PAYLOAD serialisation.
// Latency: *_started is combinational in the grant cycle; the START marker appears on the next cycle; a frame spans 2+HDR_CYCLES+PAYLOAD_CYCLES cycles including the grant.
// Backpressure: requesters hold valid until started; a response-expecting request waits while the owner FIFO is full (a same-cycle pop frees a slot).
module tx_scheduler #(
  parameter int IO_BITS         = 2,
  parameter int PAYLOAD_CYCLES  = 8,
  parameter int CMD_BITS        = 3,
  parameter int MAX_OUTSTANDING = 2,
  localparam int HDR_CYCLES     = (CMD_BITS + IO_BITS - 1) / IO_BITS,
  localparam int CNT_W          = $clog2(PAYLOAD_CYCLES) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pf_cmd_valid,
  input  logic [CMD_BITS-1:0] pf_cmd,
  output logic                pf_started,
  input  logic [IO_BITS-1:0]  pf_data,
  output logic                pf_data_next,
  input  logic                mem_cmd_valid,
  input  logic [CMD_BITS-1:0] mem_cmd,
  input  logic                mem_expect_rsp,
  output logic                mem_started,
  input  logic [IO_BITS-1:0]  mem_data,
  output logic                mem_data_next,
  output logic [IO_BITS-1:0]  tx_pins,
  output logic                tx_active,
  output logic [CNT_W-1:0]    tx_counter,
  output logic                tx_done,
  input  logic                rx_done,
  output logic                rx_owner_valid,
  output logic                rx_owner_pf
);

  localparam int HDR_W = HDR_CYCLES * IO_BITS;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_HEADER,
    S_PAYLOAD
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CMD_BITS-1:0]  r_cmd;
  logic                 r_owner_pf;
  logic                 r_rr_last_pf;

  // Owner FIFO: one bit per response-expecting frame, 1 = prefetcher.
  logic                 r_own [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [OCC_W-1:0]     r_occ;

  logic                 w_pop;
  logic                 w_room;
  logic                 w_pf_elig;
  logic                 w_mem_elig;
  logic                 w_idle;
  logic                 w_grant_pf;
  logic                 w_grant_mem;
  logic                 w_push;
  logic [PTR_W-1:0]     w_wr_nxt;
  logic [PTR_W-1:0]     w_rd_nxt;
  logic [HDR_W-1:0]     w_hdr_pad;
  logic [HDR_W-1:0]     w_hdr_sel;
  logic [IO_BITS-1:0]   w_tx_pins;

  // A pop on an empty FIFO is an RX protocol error and is simply dropped.
  assign w_pop      = rx_done && (r_occ != '0);
  // Full FIFO still has room for a new entry if the head leaves in the same cycle.
  assign w_room     = (r_occ != OCC_FULL) || w_pop;
  assign w_pf_elig  = pf_cmd_valid && w_room;
  assign w_mem_elig = mem_cmd_valid && (!mem_expect_rsp || w_room);

  // Grants are gated by rst_n so no started pulse leaks out while reset is held.
  assign w_idle      = rst_n && (r_state == S_IDLE);
  assign w_grant_pf  = w_idle && w_pf_elig && (!w_mem_elig || !r_rr_last_pf);
  assign w_grant_mem = w_idle && w_mem_elig && !w_grant_pf;
  assign w_push      = w_grant_pf || (w_grant_mem && mem_expect_rsp);

  assign w_wr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

  // Header is sent LSB first, zero-padded up to a whole number of pin-cycles.
  assign w_hdr_pad = HDR_W'(r_cmd);
  assign w_hdr_sel = w_hdr_pad >> (r_cnt * IO_BITS);

  // Pin mux: idle low, start marker, header slice, or live payload from the owner.
  always_comb begin
    w_tx_pins = '0;
    case (r_state)
      S_START:   w_tx_pins = IO_BITS'(1);
      S_HEADER:  w_tx_pins = w_hdr_sel[IO_BITS-1:0];
      S_PAYLOAD: w_tx_pins = r_owner_pf ? pf_data : mem_data;
      default:   w_tx_pins = '0;
    endcase
  end

  // Frame FSM: grant/latch in IDLE, then walk START, HEADER and PAYLOAD phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cmd        <= '0;
      r_owner_pf   <= 1'b0;
      r_rr_last_pf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_pf || w_grant_mem) begin
            r_state      <= S_START;
            r_owner_pf   <= w_grant_pf;
            r_rr_last_pf <= w_grant_pf;
            r_cmd        <= w_grant_pf ? pf_cmd : mem_cmd;
          end
        end
        S_START: begin
          r_state <= S_HEADER;
          r_cnt   <= '0;
        end
        S_HEADER: begin
          if (r_cnt == HDR_LAST) begin
            r_state <= S_PAYLOAD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (r_cnt == PAY_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Owner FIFO bookkeeping: push on grant, pop on rx_done, push+pop keeps occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_own[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_own[r_wr_ptr] <= w_grant_pf;
        r_wr_ptr        <= w_wr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

  assign pf_started     = w_grant_pf;
  assign mem_started    = w_grant_mem;
  assign pf_data_next   = (r_state == S_PAYLOAD) && r_owner_pf;
  assign mem_data_next  = (r_state == S_PAYLOAD) && !r_owner_pf;
  assign tx_pins        = w_tx_pins;
  assign tx_active      = (r_state != S_IDLE);
  assign tx_counter     = r_cnt;
  assign tx_done        = (r_state == S_PAYLOAD) && (r_cnt == PAY_LAST);
  assign rx_owner_valid = (r_occ != '0);
  assign rx_owner_pf    = r_own[r_rd_ptr];

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: frame waveform, round robin, owner FIFO limits/order, async reset.
// Inputs are driven 1 time unit after the rising edge; outputs are checked 1 unit later.
// No DUT-event waits: every step is a fixed clock count, so the run always terminates.
module tb_tx_scheduler;

  logic       clk;
  logic       rst_n;
  logic       pf_cmd_valid;
  logic [2:0] pf_cmd;
  logic       pf_started;
  logic [1:0] pf_data;
  logic       pf_data_next;
  logic       mem_cmd_valid;
  logic [2:0] mem_cmd;
  logic       mem_expect_rsp;
  logic       mem_started;
  logic [1:0] mem_data;
  logic       mem_data_next;
  logic [1:0] tx_pins;
  logic       tx_active;
  logic [3:0] tx_counter;
  logic       tx_done;
  logic       rx_done;
  logic       rx_owner_valid;
  logic       rx_owner_pf;

  int n_checks;
  int n_fail;

  tx_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pf_cmd_valid   (pf_cmd_valid),
    .pf_cmd         (pf_cmd),
    .pf_started     (pf_started),
    .pf_data        (pf_data),
    .pf_data_next   (pf_data_next),
    .mem_cmd_valid  (mem_cmd_valid),
    .mem_cmd        (mem_cmd),
    .mem_expect_rsp (mem_expect_rsp),
    .mem_started    (mem_started),
    .mem_data       (mem_data),
    .mem_data_next  (mem_data_next),
    .tx_pins        (tx_pins),
    .tx_active      (tx_active),
    .tx_counter     (tx_counter),
    .tx_done        (tx_done),
    .rx_done        (rx_done),
    .rx_owner_valid (rx_owner_valid),
    .rx_owner_pf    (rx_owner_pf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pf_cmd_valid = 1'b0;
    mem_cmd_valid = 1'b0;
    rx_done = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Called in the grant cycle (before its edge); checks START, HEADER and PAYLOAD.
  // pfv/memv are the requester valids applied once the grant edge has passed.
  task automatic frame_body(input string tag, input bit pf, input logic [2:0] cmd,
                            input bit pfv, input bit memv);
    logic [3:0] hdr;
    logic [1:0] d;
    hdr = {1'b0, cmd};
    cyc();
    pf_cmd_valid = pfv;
    mem_cmd_valid = memv;
    rx_done = 1'b0;
    #1;
    chk({tag, "_start_pins"}, tx_pins, 1);
    chk({tag, "_start_active"}, tx_active, 1);
    chk({tag, "_start_pf_started"}, pf_started, 0);
    chk({tag, "_start_mem_started"}, mem_started, 0);
    for (int h = 0; h < 2; h++) begin
      cyc();
      #1;
      chk({tag, "_hdr_pins"}, tx_pins, (h == 0) ? hdr[1:0] : hdr[3:2]);
      chk({tag, "_hdr_cnt"}, tx_counter, h);
    end
    for (int p = 0; p < 8; p++) begin
      cyc();
      d = pf ? 2'(p % 4) : 2'(3 - (p % 4));
      if (pf) begin
        pf_data = d;
        mem_data = ~d;
      end else begin
        mem_data = d;
        pf_data = ~d;
      end
      #1;
      chk({tag, "_pay_pins"}, tx_pins, d);
      chk({tag, "_pay_pf_next"}, pf_data_next, pf);
      chk({tag, "_pay_mem_next"}, mem_data_next, !pf);
      chk({tag, "_pay_cnt"}, tx_counter, p);
      chk({tag, "_pay_done"}, tx_done, (p == 7));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    pf_cmd = 3'b000;
    mem_cmd = 3'b000;
    mem_expect_rsp = 1'b0;
    pf_data = 2'b00;
    mem_data = 2'b00;
    rx_done = 1'b0;
    mem_cmd_valid = 1'b0;
    // Reset held with a pending request: no started pulse, everything quiet.
    rst_n = 1'b0;
    pf_cmd_valid = 1'b1;
    cyc();
    cyc();
    chk("rst_pins", tx_pins, 0);
    chk("rst_active", tx_active, 0);
    chk("rst_cnt", tx_counter, 0);
    chk("rst_owner_valid", rx_owner_valid, 0);
    chk("rst_pf_started", pf_started, 0);
    chk("rst_pf_next", pf_data_next, 0);
    chk("rst_done", tx_done, 0);
    pf_cmd_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // T1: single prefetcher frame, cmd 011 -> header 11,00.
    pf_cmd = 3'b011;
    pf_cmd_valid = 1'b1;
    #1;
    chk("t1_pf_started", pf_started, 1);
    chk("t1_mem_started", mem_started, 0);
    chk("t1_grant_pins", tx_pins, 0);
    chk("t1_grant_active", tx_active, 0);
    frame_body("t1", 1'b1, 3'b011, 1'b0, 1'b0);
    cyc();
    #1;
    chk("t1_gap_active", tx_active, 0);
    chk("t1_gap_pins", tx_pins, 0);
    chk("t1_gap_done", tx_done, 0);
    chk("t1_owner_valid", rx_owner_valid, 1);
    chk("t1_owner_pf", rx_owner_pf, 1);
    rx_done = 1'b1;
    cyc();
    rx_done = 1'b0;
    #1;
    chk("t1_popped", rx_owner_valid, 0);
    // Pop while empty must not disturb occupancy.
    rx_done = 1'b1;
    cyc();
    rx_done = 1'b0;
    #1;
    chk("t1_empty_pop", rx_owner_valid, 0);
    pf_cmd_valid = 1'b1;
    #1;
    chk("t1b_pf_started", pf_started, 1);
    frame_body("t1b", 1'b1, 3'b011, 1'b0, 1'b0);
    cyc();
    chk("t1b_owner_valid", rx_owner_valid, 1);
    rx_done = 1'b1;
    cyc();
    rx_done = 1'b0;
    #1;
    chk("t1b_single_entry", rx_owner_valid, 0);

    // T2: simultaneous requests after reset, both held -> pf, mem, pf.
    apply_reset();
    pf_cmd = 3'b110;
    mem_cmd = 3'b101;
    mem_expect_rsp = 1'b0;
    pf_cmd_valid = 1'b1;
    mem_cmd_valid = 1'b1;
    #1;
    chk("t2_first_pf", pf_started, 1);
    chk("t2_first_mem", mem_started, 0);
    frame_body("t2a", 1'b1, 3'b110, 1'b1, 1'b1);
    cyc();
    chk("t2_second_mem", mem_started, 1);
    chk("t2_second_pf", pf_started, 0);
    frame_body("t2b", 1'b0, 3'b101, 1'b1, 1'b1);
    cyc();
    chk("t2_third_pf", pf_started, 1);
    chk("t2_third_mem", mem_started, 0);
    frame_body("t2c", 1'b1, 3'b110, 1'b1, 1'b0);

    // T3: two pf outstanding -> pf blocked, store still goes, pop frees pf same cycle.
    cyc();
    chk("t3_pf_blocked", pf_started, 0);
    chk("t3_owner_valid", rx_owner_valid, 1);
    mem_cmd_valid = 1'b1;
    #1;
    chk("t3_store_granted", mem_started, 1);
    chk("t3_pf_still_blocked", pf_started, 0);
    frame_body("t3a", 1'b0, 3'b101, 1'b1, 1'b0);
    cyc();
    chk("t3_pf_blocked_after", pf_started, 0);
    rx_done = 1'b1;
    #1;
    chk("t3_pop_grants_pf", pf_started, 1);
    chk("t3_head_pf", rx_owner_pf, 1);
    frame_body("t3b", 1'b1, 3'b110, 1'b0, 1'b0);
    cyc();
    chk("t3_occ_kept", rx_owner_valid, 1);
    rx_done = 1'b1;
    cyc();
    chk("t3_one_left", rx_owner_valid, 1);
    chk("t3_one_left_pf", rx_owner_pf, 1);
    cyc();
    rx_done = 1'b0;
    #1;
    chk("t3_drained", rx_owner_valid, 0);

    // T4: owner order pf, mem load, pf -> 1,0,1.
    pf_cmd = 3'b001;
    mem_cmd = 3'b010;
    mem_expect_rsp = 1'b1;
    pf_cmd_valid = 1'b1;
    #1;
    chk("t4_pf_started", pf_started, 1);
    frame_body("t4a", 1'b1, 3'b001, 1'b0, 1'b1);
    cyc();
    chk("t4_load_started", mem_started, 1);
    frame_body("t4b", 1'b0, 3'b010, 1'b1, 1'b0);
    cyc();
    chk("t4_pf_full_block", pf_started, 0);
    chk("t4_head0", rx_owner_pf, 1);
    rx_done = 1'b1;
    #1;
    chk("t4_pf_on_pop", pf_started, 1);
    frame_body("t4c", 1'b1, 3'b001, 1'b0, 1'b0);
    cyc();
    chk("t4_valid1", rx_owner_valid, 1);
    chk("t4_head1", rx_owner_pf, 0);
    rx_done = 1'b1;
    cyc();
    chk("t4_valid2", rx_owner_valid, 1);
    chk("t4_head2", rx_owner_pf, 1);
    cyc();
    rx_done = 1'b0;
    #1;
    chk("t4_empty", rx_owner_valid, 0);

    // T5: async reset in payload cycle 4, then a clean frame.
    pf_cmd = 3'b011;
    pf_cmd_valid = 1'b1;
    #1;
    chk("t5_pf_started", pf_started, 1);
    cyc();
    pf_cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    pf_data = 2'd2;
    mem_data = 2'd1;
    #1;
    chk("t5_pre_cnt", tx_counter, 4);
    chk("t5_pre_pins", tx_pins, 2);
    chk("t5_pre_owner_valid", rx_owner_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pins", tx_pins, 0);
    chk("t5_rst_active", tx_active, 0);
    chk("t5_rst_cnt", tx_counter, 0);
    chk("t5_rst_owner_valid", rx_owner_valid, 0);
    chk("t5_rst_pf_next", pf_data_next, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    pf_cmd_valid = 1'b1;
    #1;
    chk("t5_regrant", pf_started, 1);
    frame_body("t5", 1'b1, 3'b011, 1'b0, 1'b0);
    cyc();
    chk("t5_end_active", tx_active, 0);
    chk("t5_end_owner_valid", rx_owner_valid, 1);
    chk("t5_end_owner_pf", rx_owner_pf, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
